// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port synchronous RAM
// Ports: clk/reset_n (async active-low); reqN/weN/addrN/wdataN in, gntN/rvalidN out per requester;
// rdata returns read data; ramAddr/ramDataIn/ramWriteEnable/ramDataOut form the RAM port;
// clearStart/clearBusy/clearDone drive the zero-fill sequencer.
// Optional zero-fill sequencer built only when RAM_ARB_CLEAR_EN is defined.
module ram_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int CLEAR_DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] ramAddr,
   output logic [DATA_WIDTH-1:0] ramDataIn,
   output logic                  ramWriteEnable,
   input  logic [DATA_WIDTH-1:0] ramDataOut,
   input  logic                  clearStart,
   output logic                  clearBusy,
   output logic                  clearDone
);
   logic                  ptr_q, ptr_d;
   logic                  rvalid0_q, rvalid1_q;
   logic                  block, clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
`ifdef RAM_ARB_CLEAR_EN
   localparam int CW = $clog2(CLEAR_DEPTH) + 1;
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q, done_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else
         case (state_q)
            IDLE: if (clearStart) begin
               state_q <= CLEAR;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
            CLEAR: if (cnt_q == CW'(CLEAR_DEPTH - 1)) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else
               cnt_q <= cnt_q + 1'b1;
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
   // A start pulse in IDLE already steals the cycle from the requesters.
   assign block     = clearStart || state_q != IDLE;
   assign clr_we    = busy_q;
   assign clr_addr  = ADDR_WIDTH'(cnt_q);
   assign clearBusy = busy_q;
   assign clearDone = done_q;
`else
   logic unused_clear;
   assign unused_clear = clearStart;
   assign block        = 1'b0;
   assign clr_we       = 1'b0;
   assign clr_addr     = '0;
   assign clearBusy    = 1'b0;
   assign clearDone    = 1'b0;
`endif
   // The pointer port only matters when both ports request.
   always_comb begin
      gnt0  = !block && req0 && (!req1 || !ptr_q);
      gnt1  = !block && req1 && (!req0 || ptr_q);
      ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ptr_q     <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         rvalid0_q <= gnt0 && !we0;
         rvalid1_q <= gnt1 && !we1;
      end
   assign rvalid0        = rvalid0_q;
   assign rvalid1        = rvalid1_q;
   assign rdata          = (rvalid0_q || rvalid1_q) ? ramDataOut : '0;
   assign ramWriteEnable = clr_we || (gnt0 && we0) || (gnt1 && we1);
   assign ramAddr        = clr_we ? clr_addr : gnt0 ? addr0 : gnt1 ? addr1 : '0;
   assign ramDataIn      = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural single-port RAM
module tb_ram_arbiter;
   logic       clk = 1'b0, reset_n = 1'b0;
   logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0, clearStart = 0;
   logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic       gnt0, gnt1, rvalid0, rvalid1, ramWriteEnable, clearBusy, clearDone;
   logic [7:0] rdata, ramAddr, ramDataIn;
   logic [7:0] ramDataOut = 8'h00;
   logic [7:0] mem [0:255] = '{default: 8'h00};
   int         errs = 0, checks = 0;

   ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLEAR_DEPTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .ramAddr(ramAddr), .ramDataIn(ramDataIn), .ramWriteEnable(ramWriteEnable),
      .ramDataOut(ramDataOut), .clearStart(clearStart), .clearBusy(clearBusy), .clearDone(clearDone));

   always #5 clk = ~clk;

   // Single-port RAM: registered read returns the pre-write contents.
   always @(posedge clk) begin
      if (ramWriteEnable) mem[ramAddr] <= ramDataIn;
      ramDataOut <= mem[ramAddr];
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                      input logic cs);
      @(negedge clk);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      clearStart = cs;
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk1({tag, "_gnt0"}, gnt0, 1'b0);
      chk1({tag, "_gnt1"}, gnt1, 1'b0);
      chk1({tag, "_rv0"}, rvalid0, 1'b0);
      chk1({tag, "_rv1"}, rvalid1, 1'b0);
      chk1({tag, "_we"}, ramWriteEnable, 1'b0);
      chk8({tag, "_rdata"}, rdata, 8'h00);
      chk8({tag, "_addr"}, ramAddr, 8'h00);
      chk1({tag, "_busy"}, clearBusy, 1'b0);
      chk1({tag, "_done"}, clearDone, 1'b0);
   endtask

   initial begin
      #1;
      chk_idle_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Write 0x5A to addr 3 then read it back through port 0.
      drv(1, 1, 8'd3, 8'h5A, 0, 0, 0, 0, 0);
      chk1("t1_wr_gnt0", gnt0, 1'b1);
      chk1("t1_wr_gnt1", gnt1, 1'b0);
      chk1("t1_wr_we", ramWriteEnable, 1'b1);
      chk8("t1_wr_addr", ramAddr, 8'd3);
      chk8("t1_wr_din", ramDataIn, 8'h5A);
      drv(1, 0, 8'd3, 8'h00, 0, 0, 0, 0, 0);
      chk1("t1_rd_gnt0", gnt0, 1'b1);
      chk1("t1_rd_we", ramWriteEnable, 1'b0);
      chk1("t1_wr_no_rv", rvalid0, 1'b0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t1_rv0", rvalid0, 1'b1);
      chk1("t1_rv1", rvalid1, 1'b0);
      chk8("t1_rdata", rdata, 8'h5A);
      chk1("t1_nogrant_gnt0", gnt0, 1'b0);
      chk8("t1_nogrant_addr", ramAddr, 8'h00);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t1_rv_one_cycle", rvalid0, 1'b0);

      // Fresh reset so the pointer starts at port 0, then both ports stream reads.
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_idle_outputs("reset2");
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1, 0, 8'd3, 0, 1, 0, 8'd3, 0, 0);
         chk1("t2_gnt0", gnt0, i[0] == 1'b0);
         chk1("t2_gnt1", gnt1, i[0] == 1'b1);
         chk1("t2_rv0", rvalid0, i != 0 && i[0] == 1'b1);
         chk1("t2_rv1", rvalid1, i != 0 && i[0] == 1'b0);
         if (i != 0) chk8("t2_rdata", rdata, 8'h5A);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t2_last_rv1", rvalid1, 1'b1);
      chk1("t2_last_rv0", rvalid0, 1'b0);
      chk8("t2_last_rdata", rdata, 8'h5A);

      // Port 0 write moves the pointer to port 1; then a write/read collision on addr 7.
      drv(1, 1, 8'd7, 8'h22, 0, 0, 0, 0, 0);
      chk1("t3_pre_gnt0", gnt0, 1'b1);
      drv(1, 0, 8'd7, 0, 1, 1, 8'd7, 8'h11, 0);
      chk1("t3_gnt1", gnt1, 1'b1);
      chk1("t3_gnt0_wait", gnt0, 1'b0);
      chk1("t3_we", ramWriteEnable, 1'b1);
      chk8("t3_addr", ramAddr, 8'd7);
      chk8("t3_din", ramDataIn, 8'h11);
      drv(1, 0, 8'd7, 0, 0, 0, 0, 0, 0);
      chk1("t3_gnt0", gnt0, 1'b1);
      chk1("t3_wr_no_rv1", rvalid1, 1'b0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t3_rv0", rvalid0, 1'b1);
      chk8("t3_rdata", rdata, 8'h11);

`ifdef RAM_ARB_CLEAR_EN
      // Preload 0..16 with non-zero data so the clear is visible and addr 16 stays intact.
      for (int i = 0; i <= 16; i++) drv(1, 1, 8'(i), 8'(8'hA0 + i), 0, 0, 0, 0, 0);
      drv(1, 0, 8'd0, 0, 0, 0, 0, 0, 0);
      chk1("t4_pre_gnt0", gnt0, 1'b1);
      drv(1, 0, 8'd15, 0, 0, 0, 0, 0, 1);
      chk1("t4_start_gnt0", gnt0, 1'b0);
      chk1("t4_start_we", ramWriteEnable, 1'b0);
      chk1("t4_start_busy", clearBusy, 1'b0);
      chk1("t4_prev_rv0", rvalid0, 1'b1);
      chk8("t4_prev_rdata", rdata, 8'hA0);
      for (int i = 0; i < 16; i++) begin
         drv(1, 0, 8'd15, 0, 0, 0, 0, 0, i == 3);
         chk1("t4_busy", clearBusy, 1'b1);
         chk1("t4_gnt0", gnt0, 1'b0);
         chk1("t4_we", ramWriteEnable, 1'b1);
         chk8("t4_addr", ramAddr, 8'(i));
         chk8("t4_din", ramDataIn, 8'h00);
         chk1("t4_done_early", clearDone, 1'b0);
      end
      drv(1, 0, 8'd15, 0, 0, 0, 0, 0, 0);
      chk1("t4_done", clearDone, 1'b1);
      chk1("t4_done_busy", clearBusy, 1'b0);
      chk1("t4_done_gnt0", gnt0, 1'b0);
      chk1("t4_done_we", ramWriteEnable, 1'b0);
      drv(1, 0, 8'd15, 0, 0, 0, 0, 0, 0);
      chk1("t4_done_once", clearDone, 1'b0);
      chk1("t4_resume_gnt0", gnt0, 1'b1);
      chk8("t4_resume_addr", ramAddr, 8'd15);
      drv(1, 0, 8'd16, 0, 0, 0, 0, 0, 0);
      chk1("t4_rd15_rv0", rvalid0, 1'b1);
      chk8("t4_rd15_rdata", rdata, 8'h00);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t4_rd16_rv0", rvalid0, 1'b1);
      chk8("t4_rd16_rdata", rdata, 8'hB0);

      // Reset part-way through a clear, then restart from address 0.
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i <= 5; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
         chk8("t5_addr", ramAddr, 8'(i));
      end
      #1 reset_n = 1'b0;
      #1;
      chk_idle_outputs("t5_reset");
      #1 reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
         chk1("t5_no_done", clearDone, 1'b0);
         chk1("t5_no_busy", clearBusy, 1'b0);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
         chk8("t5_re_addr", ramAddr, 8'(i));
         chk1("t5_re_busy", clearBusy, 1'b1);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t5_re_done", clearDone, 1'b1);
`else
      // Without the sequencer clearStart has no effect on arbitration.
      drv(1, 0, 8'd3, 0, 0, 0, 0, 0, 1);
      chk1("t6_gnt0", gnt0, 1'b1);
      chk1("t6_busy", clearBusy, 1'b0);
      drv(0, 0, 0, 0, 1, 0, 8'd7, 0, 1);
      chk1("t6_gnt1", gnt1, 1'b1);
      chk1("t6_rv0", rvalid0, 1'b1);
      chk8("t6_rdata0", rdata, 8'h5A);
      chk1("t6_busy2", clearBusy, 1'b0);
      chk1("t6_done", clearDone, 1'b0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t6_rv1", rvalid1, 1'b1);
      chk8("t6_rdata1", rdata, 8'h11);
      chk1("t6_done2", clearDone, 1'b0);
      chk1("t6_we", ramWriteEnable, 1'b0);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port synchronous RAM: one access per cycle, registered read data, fixed 1-cycle read latency.
- Routes each winner's address, data and write enable onto the RAM port.
- Returns read data to the requester that issued the read.
- Optional clear sequencer zero-fills a configurable address range.

Parameters:
DATA_WIDTH, 8, data width; equals RAM DATA_WIDTH
ADDR_WIDTH, 32, address width; equals RAM ADDR_WIDTH
CLEAR_DEPTH, 256, words zeroed by the clear sequence; 1 <= CLEAR_DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
req0 / req1  in  1  access request, port 0 / port 1
we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
addr0 / addr1  in  ADDR_WIDTH  access address
wdata0 / wdata1  in  DATA_WIDTH  write data
gnt0 / gnt1  out  1  combinational grant; request accepted this cycle
rvalid0 / rvalid1  out  1  read data valid for port N
rdata  out  DATA_WIDTH  read data; meaningful only when an rvalidN is high
ramAddr  out  ADDR_WIDTH  to RAM addr
ramDataIn  out  DATA_WIDTH  to RAM dataIn
ramWriteEnable  out  1  to RAM writeEnable
ramDataOut  in  DATA_WIDTH  from RAM dataOut (registered inside the RAM)
clearStart  in  1  one-cycle pulse; start zero-fill
clearBusy  out  1  clear sequence in progress
clearDone  out  1  one-cycle pulse after the last clear write

Behaviour:
- Reset (reset_n low, async):
  - gnt0/1, rvalid0/1, ramWriteEnable, clearBusy and clearDone are 0; rdata = 0.
  - Priority pointer = port 0; clear FSM = IDLE.
- Handshake:
  - Requester holds reqN, weN, addrN and wdataN stable until the cycle gntN = 1.
  - Transfer happens on the clock edge where reqN and gntN are both 1.
  - A requester may drop reqN before it is granted.
- Arbitration (combinational):
  - Only one requesting port: it wins.
  - Both requesting: the pointer port wins.
  - At most one gnt per cycle.
  - After a grant to port k, the pointer moves to the other port; with no grant, the pointer holds.
- RAM drive:
  - Granted cycle: ramAddr = addrN, ramDataIn = wdataN, ramWriteEnable = weN.
  - No grant: ramWriteEnable = 0, ramAddr = 0, ramDataIn = 0.
- Read return:
  - rvalidN is registered: 1 in the cycle after a read grant to port N, for exactly one cycle.
  - rdata = ramDataOut in that cycle.
  - Back-to-back reads return back-to-back, alternating ports when both stream.
  - A write grant produces no rvalid.
- Read-during-write: the RAM samples old data on a write edge. A read granted the cycle after a write to the same address returns the new data.
- Clear FSM, states IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: clearStart = 1 -> CLEAR, with address counter = 0.
  - CLEAR:
    - Each cycle drives ramAddr = counter, ramDataIn = 0, ramWriteEnable = 1, then increments the counter.
    - gnt0/1 forced 0; requests stall while held.
    - After address CLEAR_DEPTH-1 is written -> DONE.
    - clearBusy = 1 throughout.
  - DONE: clearDone = 1 for one cycle -> IDLE. Arbitration resumes in the following cycle.
  - clearStart in CLEAR or DONE is ignored.
  - clearStart in IDLE in the same cycle as a request: clear wins and no gnt is issued. A read granted in the previous cycle still returns its rvalid.
  - Counter width is $clog2(CLEAR_DEPTH)+1 bits, with no wrap. CLEAR_DEPTH = 1 gives a single clear write.
- Reset mid-operation: all state returns to reset values immediately. A pending rvalid is dropped; a partial clear is abandoned and clearDone is not pulsed.

Optional Feature:
- Macro RAM_ARB_CLEAR_EN.
- Defined: clear FSM and counter built as specified above.
- Undefined: no clear logic is built; clearStart is ignored; clearBusy and clearDone are tied 0; the arbiter is otherwise identical.

Test Plan:
1. Port 0 writes 0x5A to addr 3, then port 0 reads addr 3 -> gnt0 one cycle each; rvalid0 = 1 with rdata = 0x5A one cycle after the read grant; rvalid1 stays 0.
2. req0 and req1 both held high for 4 cycles, all reads, after reset -> grant order 0, 1, 0, 1; each rvalid is one cycle after its grant, never two gnts in one cycle.
3. Port 1 writes 0x11 to addr 7 while port 0 requests a read of addr 7 in the same cycle (pointer = 1) -> port 1 granted first; port 0 granted next cycle and returns 0x11.
4. Memory preloaded non-zero, CLEAR_DEPTH = 16, clearStart pulsed with req0 held high -> clearBusy high for 16 cycles, addresses 0..15 written with 0, gnt0 held 0, clearDone pulses once; gnt0 on the next cycle and a read of addr 15 returns 0x00.
5. reset_n driven low mid-clear at counter = 5, then released -> all outputs 0 and clearDone never pulses; a new clearStart restarts at addr 0.
6. Build without RAM_ARB_CLEAR_EN; pulse clearStart during reads -> clearBusy and clearDone stay 0; arbitration unaffected.
